// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS subset
//            with memory-handshake stall, timeout and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Count value seen on the WAIT_MAX-th consecutive wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               retire;
  logic               timeout;

  assign timeout = (wait_q == WAIT_LAST);

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    state_d     = state_q;
    wait_d      = 8'd0;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    retire      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RWB;
      end

      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase

    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed self-checking bench for the multi-cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam int CNT_W = 32;

  // Control word: {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,
  //                memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsource}
  localparam logic [15:0] C_NONE    = 16'h0000;
  localparam logic [15:0] C_FETCHW  = 16'h1010;
  localparam logic [15:0] C_FETCHR  = 16'h9410;
  localparam logic [15:0] C_DECODE  = 16'h0030;
  localparam logic [15:0] C_MEMADR  = 16'h0060;
  localparam logic [15:0] C_MEMRD   = 16'h3000;
  localparam logic [15:0] C_MEMWB   = 16'h0280;
  localparam logic [15:0] C_MEMWR   = 16'h2800;
  localparam logic [15:0] C_EXEC    = 16'h0048;
  localparam logic [15:0] C_RWB     = 16'h0180;
  localparam logic [15:0] C_BRANCH  = 16'h4045;
  localparam logic [15:0] C_JUMP    = 16'h8002;
  localparam logic [15:0] C_ADDIEX  = 16'h0060;
  localparam logic [15:0] C_ADDIWB  = 16'h0080;

  logic             r_clk;
  logic             r_rst_n;
  logic [5:0]       r_opcode;
  logic             r_mem_ready;
  logic             w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
  logic             w_irwrite, w_memtoreg, w_regdst, w_regwrite, w_alusrca;
  logic [1:0]       w_alusrcb, w_aluop, w_pcsource;
  logic             w_illegal, w_bus_err;
  logic [CNT_W-1:0] w_instret;
  logic [3:0]       w_state;
  logic [15:0]      w_ctrl;

  int r_checks = 0;
  int r_errors = 0;

  multicycle_control #(.WAIT_MAX(15), .CNT_W(CNT_W)) u_dut (
    .clk         (r_clk),
    .rst_n       (r_rst_n),
    .opcode      (r_opcode),
    .mem_ready   (r_mem_ready),
    .pcwrite     (w_pcwrite),
    .pcwritecond (w_pcwritecond),
    .iord        (w_iord),
    .memread     (w_memread),
    .memwrite    (w_memwrite),
    .irwrite     (w_irwrite),
    .memtoreg    (w_memtoreg),
    .regdst      (w_regdst),
    .regwrite    (w_regwrite),
    .alusrca     (w_alusrca),
    .alusrcb     (w_alusrcb),
    .aluop       (w_aluop),
    .pcsource    (w_pcsource),
    .illegal     (w_illegal),
    .bus_err     (w_bus_err),
    .instret     (w_instret),
    .state       (w_state)
  );

  assign w_ctrl = {w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite,
                   w_irwrite, w_memtoreg, w_regdst, w_regwrite, w_alusrca,
                   w_alusrcb, w_aluop, w_pcsource};

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and check state plus full control word.
  task automatic step(input string tag, input logic [3:0] st, input logic [15:0] ctrl);
    @(posedge r_clk);
    #2;
    chk({tag, ".state"}, 64'(w_state), 64'(st));
    chk({tag, ".ctrl"},  64'(w_ctrl),  64'(ctrl));
  endtask

  task automatic do_reset();
    r_rst_n     = 1'b0;
    r_mem_ready = 1'b1;
    r_opcode    = 6'b000000;
    repeat (2) @(posedge r_clk);
    #2;
    r_rst_n = 1'b1;
  endtask

  initial begin
    int bad;

    // 1: reset, then an R-type add with memory always ready
    do_reset();
    chk("rst.state",   64'(w_state),   64'd0);
    chk("rst.ctrl",    64'(w_ctrl),    64'(C_NONE));
    chk("rst.illegal", 64'(w_illegal), 64'd0);
    chk("rst.bus_err", 64'(w_bus_err), 64'd0);
    chk("rst.instret", 64'(w_instret), 64'd0);
    r_opcode = 6'b000000;
    step("add.fetch",  4'd1, C_FETCHR);
    step("add.decode", 4'd2, C_DECODE);
    step("add.exec",   4'd7, C_EXEC);
    step("add.rwb",    4'd8, C_RWB);
    step("add.fetch2", 4'd1, C_FETCHR);
    chk("add.instret", 64'(w_instret), 64'd1);

    // 2: lw with three stall cycles in MEMRD
    do_reset();
    r_opcode = 6'b100011;
    step("lw.fetch",  4'd1, C_FETCHR);
    step("lw.decode", 4'd2, C_DECODE);
    step("lw.memadr", 4'd3, C_MEMADR);
    r_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw.memrd_wait", 4'd4, C_MEMRD);
    r_mem_ready = 1'b1;
    #1;
    chk("lw.memrd_done.ctrl", 64'(w_ctrl), 64'(C_MEMRD));
    step("lw.memwb",  4'd5, C_MEMWB);
    step("lw.fetch2", 4'd1, C_FETCHR);
    chk("lw.instret", 64'(w_instret), 64'd1);

    // 3: sw, beq, j, addi back-to-back
    do_reset();
    r_opcode = 6'b101011;
    step("sw.fetch",  4'd1, C_FETCHR);
    step("sw.decode", 4'd2, C_DECODE);
    step("sw.memadr", 4'd3, C_MEMADR);
    step("sw.memwr",  4'd6, C_MEMWR);
    step("beq.fetch", 4'd1, C_FETCHR);
    r_opcode = 6'b000100;
    step("beq.decode", 4'd2, C_DECODE);
    step("beq.branch", 4'd9, C_BRANCH);
    step("j.fetch",    4'd1, C_FETCHR);
    r_opcode = 6'b000010;
    step("j.decode",   4'd2, C_DECODE);
    step("j.jump",     4'd10, C_JUMP);
    step("addi.fetch", 4'd1, C_FETCHR);
    r_opcode = 6'b001000;
    step("addi.decode", 4'd2, C_DECODE);
    step("addi.ex",     4'd11, C_ADDIEX);
    step("addi.wb",     4'd12, C_ADDIWB);
    step("seq.fetch",   4'd1, C_FETCHR);
    chk("seq.instret", 64'(w_instret), 64'd4);

    // 4: illegal opcode halts and holds
    do_reset();
    r_opcode = 6'b111111;
    step("ill.fetch",  4'd1, C_FETCHR);
    step("ill.decode", 4'd2, C_DECODE);
    step("ill.halt",   4'd13, C_NONE);
    chk("ill.illegal", 64'(w_illegal), 64'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge r_clk);
      #2;
      if (w_state !== 4'd13 || w_ctrl !== 16'h0000) bad++;
    end
    chk("ill.hold_bad_cycles", 64'(bad), 64'd0);
    chk("ill.sticky", 64'(w_illegal), 64'd1);
    chk("ill.instret", 64'(w_instret), 64'd0);

    // 5a: FETCH never acknowledged -> bus error after 15 cycles
    do_reset();
    r_mem_ready = 1'b0;
    step("to.fetch1", 4'd1, C_FETCHW);
    for (int i = 0; i < 14; i++) step("to.fetch_wait", 4'd1, C_FETCHW);
    chk("to.bus_err_before", 64'(w_bus_err), 64'd0);
    step("to.halt", 4'd13, C_NONE);
    chk("to.bus_err", 64'(w_bus_err), 64'd1);
    repeat (3) @(posedge r_clk);
    #2;
    chk("to.bus_err_sticky", 64'(w_bus_err), 64'd1);
    chk("to.halt_hold", 64'(w_state), 64'd13);

    // 5b: mem_ready on the 15th wait cycle completes normally
    do_reset();
    r_mem_ready = 1'b0;
    r_opcode    = 6'b000000;
    step("to2.fetch1", 4'd1, C_FETCHW);
    for (int i = 0; i < 14; i++) step("to2.fetch_wait", 4'd1, C_FETCHW);
    r_mem_ready = 1'b1;
    #1;
    chk("to2.fetch15.ctrl", 64'(w_ctrl), 64'(C_FETCHR));
    step("to2.decode", 4'd2, C_DECODE);
    chk("to2.bus_err", 64'(w_bus_err), 64'd0);

    // 6: asynchronous reset in the middle of a store
    do_reset();
    r_opcode = 6'b000000;
    step("ar.fetch",  4'd1, C_FETCHR);
    step("ar.decode", 4'd2, C_DECODE);
    step("ar.exec",   4'd7, C_EXEC);
    step("ar.rwb",    4'd8, C_RWB);
    r_opcode = 6'b101011;
    step("ar.sw_fetch",  4'd1, C_FETCHR);
    chk("ar.instret_pre", 64'(w_instret), 64'd1);
    step("ar.sw_decode", 4'd2, C_DECODE);
    step("ar.sw_memadr", 4'd3, C_MEMADR);
    r_mem_ready = 1'b0;
    step("ar.sw_memwr",  4'd6, C_MEMWR);
    #1;
    r_rst_n = 1'b0;
    #1;
    chk("ar.memwrite", 64'(w_memwrite), 64'd0);
    chk("ar.state",    64'(w_state),    64'd0);
    chk("ar.instret",  64'(w_instret),  64'd0);
    do_reset();
    step("ar.restart", 4'd1, C_FETCHR);

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule

`default_nettype wire
